// File: rtl/mandelbrot_scan_if.sv
// Sample stream from the Mandelbrot scanner to the iterator feed.
// A sample transfers on any rising edge where out_valid && out_ready. Once out_valid
// rises, it and all payload fields stay stable until that transfer happens.
// out_valid never depends combinationally on out_ready.
interface mandelbrot_scan_if #(
    parameter int WIDTH = 20,
    parameter int XW    = 10,
    parameter int YW    = 9
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] c_real_out;
    logic signed [WIDTH-1:0] c_imag_out;
    logic [XW-1:0]           pix_x;
    logic [YW-1:0]           pix_y;

    modport master (
        output out_valid, c_real_out, c_imag_out, pix_x, pix_y,
        input  out_ready
    );

    modport slave (
        input  out_valid, c_real_out, c_imag_out, pix_x, pix_y,
        output out_ready
    );
endinterface

// File: rtl/mandelbrot_scan.sv
// Raster scanner producing one c value per pixel for a Mandelbrot iterator pipeline.
// Define MANDELBROT_SCAN_CONTINUOUS_EN to rescan frames back to back without start.
module mandelbrot_scan #(
    parameter int WIDTH = 20,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] origin_re,
    input  logic signed [WIDTH-1:0] origin_im,
    input  logic signed [WIDTH-1:0] step_re,
    input  logic signed [WIDTH-1:0] step_im,
    mandelbrot_scan_if.master       bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic [1:0]              state_dbg
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_n;
    logic signed [WIDTH-1:0] org_re, org_im, stp_re, stp_im;
    logic xfer, last_x, last_y, load;

    assign xfer      = bus.out_valid && bus.out_ready;
    assign last_x    = (bus.pix_x == XW'(H_RES - 1));
    assign last_y    = (bus.pix_y == YW'(V_RES - 1));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (xfer && last_x && last_y) state_n = DONE;
            end
            DONE: begin
`ifdef MANDELBROT_SCAN_CONTINUOUS_EN
                state_n = RUN;
                load    = 1'b1;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.c_real_out <= '0;
            bus.c_imag_out <= '0;
            bus.pix_x      <= '0;
            bus.pix_y      <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            org_re         <= '0;
            org_im         <= '0;
            stp_re         <= '0;
            stp_im         <= '0;
        end else begin
            bus.out_valid <= (state_n == RUN);
            busy          <= (state_n != IDLE);
            frame_done    <= (state_n == DONE);
            if (load) begin
                org_re         <= origin_re;
                org_im         <= origin_im;
                stp_re         <= step_re;
                stp_im         <= step_im;
                bus.c_real_out <= origin_re;
                bus.c_imag_out <= origin_im;
                bus.pix_x      <= '0;
                bus.pix_y      <= '0;
            end else if (state == RUN && xfer) begin
                // Wrapping adds only; the final pixel leaves the payload as it was.
                if (!last_x) begin
                    bus.pix_x      <= bus.pix_x + XW'(1);
                    bus.c_real_out <= bus.c_real_out + stp_re;
                end else if (!last_y) begin
                    bus.pix_x      <= '0;
                    bus.pix_y      <= bus.pix_y + YW'(1);
                    bus.c_real_out <= org_re;
                    bus.c_imag_out <= bus.c_imag_out + stp_im;
                end
            end
        end
    end
endmodule
